// File: rtl/escalonador_somador_pkg.sv
// Shared constants for the adder sequencer: FSM encodings,
// adder select polarity and default sizes.
package escalonador_somador_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic SEL_ADD = 1'b1;
  localparam logic SEL_SUB = 1'b0;

  localparam int N_DEF = 4;
  localparam int W_DEF = 4;

endpackage

// File: rtl/escalonador_somador_rr_picker.sv
// Round-robin priority select: first req at or after ptr.
// Ports: req, ptr in; win_oh (one-hot), win_idx, any out.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [PW-1:0] win_idx,
  output logic          any
);

  int j;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any        = 1'b1;
        win_oh[j]  = 1'b1;
        win_idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/somador_subtrator.sv
// Shared W-bit adder/subtractor, W+1-bit result.
// Ports: a, b, select (1=add, 0=sub) in; resul out.
module somador_subtrator #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         select,
  output logic [W:0]   resul
);

  always_comb begin
    if (select) resul = {1'b0, a} + {1'b0, b};
    else        resul = {1'b0, a} - {1'b0, b};
  end

endmodule

// File: rtl/escalonador_somador.sv
// Round-robin sequencer sharing one somador_subtrator among N
// requesters: IDLE->EXEC->DONE, one op per 3 cycles.
// Ports: clock, reset_n; req/a_in/b_in/sel_in from requesters;
// gnt, resul_valid, resul_out, busy back; alu_a/alu_b/alu_select
// to the adder, alu_resul from it.
// Option: ESCALONADOR_SATURA_EN clamps sub underflow to 0.
module escalonador_somador
  import escalonador_somador_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  input  logic [N-1:0]   sel_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   resul_valid,
  output logic [W:0]     resul_out,
  output logic           busy,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_select,
  input  logic [W:0]     alu_resul
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] ptr_next;
  logic [N-1:0]  win_oh;
  logic [PW-1:0] win_idx;
  logic          any;
  logic [N-1:0]  own_oh;
  logic [W:0]    res_next;

  rr_picker #(.N(N), .PW(PW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (any)
  );

  assign busy = (state != ST_IDLE);

  assign ptr_next = (owner == PW'(N-1)) ? '0
                                        : owner + 1'b1;

  always_comb begin
    own_oh        = '0;
    own_oh[owner] = 1'b1;
  end

  // alu_select still holds the captured op during EXEC.
  always_comb begin
    res_next = alu_resul;
`ifdef ESCALONADOR_SATURA_EN
    if (alu_select == SEL_SUB && alu_resul[W])
      res_next = '0;
`endif
  end

  // alu_* double as the op regs: loaded once at grant,
  // untouched until the next grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      owner       <= '0;
      gnt         <= '0;
      resul_valid <= '0;
      resul_out   <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_select  <= SEL_ADD;
    end else begin
      gnt         <= '0;
      resul_valid <= '0;
      unique case (state)
        ST_IDLE: begin
          if (any) begin
            alu_a      <= a_in[win_idx*W +: W];
            alu_b      <= b_in[win_idx*W +: W];
            alu_select <= sel_in[win_idx];
            owner      <= win_idx;
            gnt        <= win_oh;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resul_out   <= res_next;
          resul_valid <= own_oh;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          ptr   <= ptr_next;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_somador.sv
// Directed bench for escalonador_somador with a real
// somador_subtrator on the alu_* ports (N=4, W=4).
module tb_escalonador_somador;

  localparam int N = 4;
  localparam int W = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   sel_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   resul_valid;
  logic [W:0]     resul_out;
  logic           busy;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic           alu_select;
  logic [W:0]     alu_resul;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clock = ~clock;

  escalonador_somador #(.N(N), .W(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .a_in        (a_in),
    .b_in        (b_in),
    .sel_in      (sel_in),
    .gnt         (gnt),
    .resul_valid (resul_valid),
    .resul_out   (resul_out),
    .busy        (busy),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_select  (alu_select),
    .alu_resul   (alu_resul)
  );

  somador_subtrator #(.W(W)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .select (alu_select),
    .resul  (alu_resul)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got %0h want %0h", tag, got, exp);
  endtask

  task automatic set_op(input int i,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic s);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
    sel_in[i]      = s;
  endtask

  task automatic wait_gnt(output logic [N-1:0] g);
    g = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (gnt != '0) begin
        g = gnt;
        break;
      end
    end
  endtask

  logic [N-1:0] g;
  logic [N-1:0] vseen;
  int           ngnt;
  int           rr_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset_n = 1'b0;
    req     = '0;
    a_in    = '0;
    b_in    = '0;
    sel_in  = '0;
    repeat (2) @(negedge clock);
    check("rst_gnt", gnt, 0);
    check("rst_valid", resul_valid, 0);
    check("rst_res", resul_out, 0);
    check("rst_busy", busy, 0);
    check("rst_sel", alu_select, 1);
    reset_n = 1'b1;
    @(negedge clock);

    // single add, requester 0: 3+1
    set_op(0, 4'd3, 4'd1, 1'b1);
    req = 4'b0001;
    @(negedge clock);
    check("add_gnt", gnt, 4'b0001);
    check("add_busy1", busy, 1);
    check("add_alua", alu_a, 3);
    check("add_alub", alu_b, 1);
    req = '0;
    @(negedge clock);
    check("add_valid", resul_valid, 4'b0001);
    check("add_res", resul_out, 5'd4);
    check("add_gnt_off", gnt, 0);
    check("add_busy2", busy, 1);
    @(negedge clock);
    check("add_idle", busy, 0);
    check("add_vclr", resul_valid, 0);
    check("add_hold", resul_out, 5'd4);

    // subtract, requester 2: 3-1 then 1-1
    set_op(2, 4'd3, 4'd1, 1'b0);
    req = 4'b0100;
    wait_gnt(g);
    check("sub_gnt", g, 4'b0100);
    check("sub_sel", alu_select, 0);
    req = '0;
    @(negedge clock);
    check("sub_valid", resul_valid, 4'b0100);
    check("sub_res", resul_out, 5'd2);
    set_op(2, 4'd1, 4'd1, 1'b0);
    req = 4'b0100;
    wait_gnt(g);
    check("sub0_gnt", g, 4'b0100);
    req = '0;
    @(negedge clock);
    check("sub0_res", resul_out, 5'd0);

    // underflow, requester 1: 1-4
    set_op(1, 4'd1, 4'd4, 1'b0);
    req = 4'b0010;
    wait_gnt(g);
    check("uf_gnt", g, 4'b0010);
    req = '0;
    @(negedge clock);
    check("uf_valid", resul_valid, 4'b0010);
`ifdef ESCALONADOR_SATURA_EN
    check("uf_res", resul_out, 5'd0);
`else
    check("uf_res", resul_out, 5'b11101);
`endif
    @(negedge clock);

    // reset while EXEC: op abandoned, ptr back to 0
    set_op(2, 4'd5, 4'd2, 1'b1);
    req = 4'b0100;
    wait_gnt(g);
    check("mid_gnt", g, 4'b0100);
    req = '0;
    #2 reset_n = 1'b0;
    #1;
    check("mid_gnt0", gnt, 0);
    check("mid_busy", busy, 0);
    check("mid_valid", resul_valid, 0);
    check("mid_res", resul_out, 0);
    check("mid_alua", alu_a, 0);
    check("mid_sel", alu_select, 1);
    #1 reset_n = 1'b1;
    vseen = '0;
    repeat (4) begin
      @(negedge clock);
      vseen |= resul_valid;
    end
    check("mid_novalid", vseen, 0);
    set_op(0, 4'd2, 4'd2, 1'b1);
    set_op(3, 4'd7, 4'd7, 1'b1);
    req = 4'b1001;
    wait_gnt(g);
    check("mid_ptr0", g, 4'b0001);
    req = '0;
    @(negedge clock);
    check("mid_res2", resul_out, 5'd4);
    @(negedge clock);

    // round-robin with all four requesting
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    for (int i = 0; i < N; i++)
      set_op(i, W'(i), 4'd1, 1'b1);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_gnt(g);
      check("rr_gnt", g, 4'b0001 << rr_order[n]);
      req = req & ~g;
      @(negedge clock);
      check("rr_valid", resul_valid, g);
      check("rr_res", resul_out, rr_order[n] + 1);
      req = req | g;
    end
    req = '0;
    repeat (3) @(negedge clock);

    // late request held across EXEC/DONE, pulse ignored
    set_op(0, 4'd6, 4'd3, 1'b0);
    set_op(3, 4'd9, 4'd6, 1'b1);
    req = 4'b0001;
    wait_gnt(g);
    check("gap_gnt0", g, 4'b0001);
    req = 4'b1100;
    @(negedge clock);
    check("gap_res0", resul_out, 5'd3);
    req = 4'b1000;
    wait_gnt(g);
    check("gap_gnt3", g, 4'b1000);
    req = '0;
    @(negedge clock);
    check("gap_res3", resul_out, 5'd15);
    ngnt = 0;
    repeat (8) begin
      @(negedge clock);
      if (gnt != '0) ngnt++;
    end
    check("gap_nodup", ngnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
